// File: rtl/pc_redirect_unit.sv
// Fetch PC register with a redirect sequencer: accepts branch/jump redirects,
// defers them across stalls, and raises a fixed-length flush after each one.
module pc_redirect_unit #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_PC     = '0,
   parameter int              FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic            jump,
   input  logic [XLEN-1:0] target,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            flush,
   output logic            redirect_busy,
   output logic            misalign_err
);

   if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3) begin : g_bad_flush_cycles
      $error("pc_redirect_unit: FLUSH_CYCLES must be in 1..3");
   end

   typedef enum logic [1:0] {
      S_RUN,
      S_HOLD,
      S_FLUSH
   } state_t;

   localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

   state_t          state;
   logic [1:0]      cnt;
   logic [XLEN-1:0] pend_target;
   logic            redir;
   logic [XLEN-1:0] eff_target;

   assign redir      = branch_taken | jump;
   assign eff_target = target & ~XLEN'(1);
   assign pc_plus4   = pc + XLEN'(4);

   // flush and redirect_busy are registered alongside state so they track it exactly
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_RUN;
         pc            <= RESET_PC;
         cnt           <= 2'd0;
         pend_target   <= '0;
         flush         <= 1'b0;
         redirect_busy <= 1'b0;
         misalign_err  <= 1'b0;
      end else begin
         case (state)
            S_RUN: begin
               if (redir) begin
                  misalign_err  <= misalign_err | target[1];
                  redirect_busy <= 1'b1;
                  if (stall) begin
                     pend_target <= eff_target;
                     state       <= S_HOLD;
                  end else begin
                     pc    <= eff_target;
                     cnt   <= CNT_INIT;
                     flush <= 1'b1;
                     state <= S_FLUSH;
                  end
               end else if (!stall) begin
                  pc <= pc_plus4;
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  pc    <= pend_target;
                  cnt   <= CNT_INIT;
                  flush <= 1'b1;
                  state <= S_FLUSH;
               end
            end
            // Redirects seen here come from wrong-path instructions and are dropped
            S_FLUSH: begin
               if (!stall) begin
                  pc <= pc_plus4;
                  if (cnt == 2'd0) begin
                     flush         <= 1'b0;
                     redirect_busy <= 1'b0;
                     state         <= S_RUN;
                  end else begin
                     cnt <= cnt - 2'd1;
                  end
               end
            end
            default: begin
               flush         <= 1'b0;
               redirect_busy <= 1'b0;
               state         <= S_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Testbench for pc_redirect_unit: directed scenarios with literal expectations,
// then random traffic compared each cycle against a behavioural model.
module tb_pc_redirect_unit;

   localparam int FLUSH_N = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic        jump = 1'b0;
   logic [31:0] target = '0;
   logic [31:0] pc, pc_plus4;
   logic        flush, redirect_busy, misalign_err;
   logic [31:0] w_pc, w_pc_plus4;
   logic        w_flush, w_busy, w_mis;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b1;

   pc_redirect_unit #(.XLEN(32), .RESET_PC(32'h0), .FLUSH_CYCLES(FLUSH_N)) dut (
      .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken), .jump(jump),
      .target(target), .pc(pc), .pc_plus4(pc_plus4), .flush(flush),
      .redirect_busy(redirect_busy), .misalign_err(misalign_err)
   );

   pc_redirect_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .FLUSH_CYCLES(FLUSH_N)) wrap_dut (
      .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken), .jump(jump),
      .target(target), .pc(w_pc), .pc_plus4(w_pc_plus4), .flush(w_flush),
      .redirect_busy(w_busy), .misalign_err(w_mis)
   );

   always #5 clk = ~clk;

   // Model: a redirect either lands now or waits in m_pend; m_left counts unstalled flush cycles still owed
   logic [31:0] m_pc = '0;
   logic [31:0] m_pend = '0;
   bit          m_waiting = 1'b0;
   int          m_left = 0;
   bit          m_mis = 1'b0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_pc <= '0; m_pend <= '0; m_waiting <= 1'b0; m_left <= 0; m_mis <= 1'b0;
      end else if (m_left > 0) begin
         if (!stall) begin
            m_pc   <= m_pc + 32'd4;
            m_left <= m_left - 1;
         end
      end else if (m_waiting) begin
         if (!stall) begin
            m_pc      <= m_pend;
            m_left    <= FLUSH_N;
            m_waiting <= 1'b0;
         end
      end else if (branch_taken || jump) begin
         if (target[1]) m_mis <= 1'b1;
         if (stall) begin
            m_pend    <= {target[31:1], 1'b0};
            m_waiting <= 1'b1;
         end else begin
            m_pc   <= {target[31:1], 1'b0};
            m_left <= FLUSH_N;
         end
      end else if (!stall) begin
         m_pc <= m_pc + 32'd4;
      end
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check_output("model_pc", pc, m_pc);
         check_output("model_pc_plus4", pc_plus4, m_pc + 32'd4);
         check_output("model_flush", 32'(flush), 32'(m_left > 0));
         check_output("model_busy", 32'(redirect_busy), 32'(m_left > 0 || m_waiting));
         check_output("model_misalign", 32'(misalign_err), 32'(m_mis));
      end
   end

   task automatic apply_stimulus(input logic s, input logic b, input logic j, input logic [31:0] t);
      stall = s; branch_taken = b; jump = j; target = t;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_state(input string tag, input logic [31:0] epc, input logic ef,
                               input logic eb);
      check_output({tag, "_pc"}, pc, epc);
      check_output({tag, "_flush"}, 32'(flush), 32'(ef));
      check_output({tag, "_busy"}, 32'(redirect_busy), 32'(eb));
   endtask

   task automatic async_reset(input string tag);
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      expect_state(tag, 32'h0, 1'b0, 1'b0);
      check_output({tag, "_misalign"}, 32'(misalign_err), 32'h0);
      stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; target = '0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      // T1: power-on reset, count, reset mid-run, count again
      repeat (2) @(posedge clk);
      #1;
      expect_state("t1_rst", 32'h0, 1'b0, 1'b0);
      check_output("t5_wrap_reset_pc", w_pc, 32'hFFFF_FFFC);
      rst = 1'b1;
      apply_stimulus(0, 0, 0, 0);
      check_output("t5_wrap_pc", w_pc, 32'h0);
      expect_state("t1_c1", 32'h4, 1'b0, 1'b0);
      apply_stimulus(0, 0, 0, 0);
      apply_stimulus(0, 0, 0, 0);
      expect_state("t1_c3", 32'hC, 1'b0, 1'b0);
      async_reset("t1_midrun");
      apply_stimulus(0, 0, 0, 0);
      check_output("t1_after_pc", pc, 32'h4);
      apply_stimulus(0, 0, 0, 0);
      apply_stimulus(0, 0, 0, 0);
      apply_stimulus(0, 0, 0, 0);
      check_output("t2_pre_pc", pc, 32'h10);

      // T2: taken branch
      apply_stimulus(0, 1, 0, 32'h40);
      expect_state("t2_a", 32'h40, 1'b1, 1'b1);
      check_output("t2_pc_plus4", pc_plus4, 32'h44);
      apply_stimulus(0, 0, 0, 0);
      expect_state("t2_b", 32'h44, 1'b1, 1'b1);
      apply_stimulus(0, 0, 0, 0);
      expect_state("t2_c", 32'h48, 1'b0, 1'b0);

      // T3: redirect during stall is held, bit 0 of target cleared
      apply_stimulus(1, 0, 1, 32'h81);
      expect_state("t3_hold1", 32'h48, 1'b0, 1'b1);
      apply_stimulus(1, 0, 0, 32'h500);
      apply_stimulus(1, 1, 0, 32'h600);
      expect_state("t3_hold3", 32'h48, 1'b0, 1'b1);
      apply_stimulus(0, 0, 0, 0);
      expect_state("t3_go", 32'h80, 1'b1, 1'b1);
      apply_stimulus(0, 0, 0, 0);
      apply_stimulus(0, 0, 0, 0);
      expect_state("t3_done", 32'h88, 1'b0, 1'b0);
      check_output("t3_misalign", 32'(misalign_err), 32'h0);

      // T4: redirects during flush are ignored
      apply_stimulus(0, 1, 0, 32'h100);
      apply_stimulus(0, 1, 0, 32'h200);
      expect_state("t4_a", 32'h104, 1'b1, 1'b1);
      apply_stimulus(0, 1, 1, 32'h200);
      expect_state("t4_b", 32'h108, 1'b0, 1'b0);

      // T5: misaligned target sets the sticky error
      apply_stimulus(0, 0, 1, 32'h102);
      check_output("t5_pc", pc, 32'h102);
      check_output("t5_mis", 32'(misalign_err), 32'h1);
      apply_stimulus(0, 0, 0, 0);
      apply_stimulus(0, 0, 0, 0);
      expect_state("t5_after", 32'h10A, 1'b0, 1'b0);
      check_output("t5_mis_sticky", 32'(misalign_err), 32'h1);

      // T6: stall inside flush, then reset while holding
      apply_stimulus(0, 1, 0, 32'h300);
      apply_stimulus(1, 0, 0, 0);
      apply_stimulus(1, 0, 0, 0);
      expect_state("t6_stalled", 32'h300, 1'b1, 1'b1);
      apply_stimulus(0, 0, 0, 0);
      expect_state("t6_f2", 32'h304, 1'b1, 1'b1);
      apply_stimulus(0, 0, 0, 0);
      expect_state("t6_end", 32'h308, 1'b0, 1'b0);
      apply_stimulus(1, 0, 1, 32'h400);
      expect_state("t6_hold", 32'h308, 1'b0, 1'b1);
      async_reset("t6_rst_hold");
      apply_stimulus(0, 0, 0, 0);
      expect_state("t6_no_pend", 32'h4, 1'b0, 1'b0);

      // Random traffic checked by the compare process against the model
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] t;
         t = $urandom;
         if ($urandom_range(0, 3) == 0) t[31:12] = 20'h0;
         rst = ($urandom_range(0, 249) != 0);
         apply_stimulus(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 4) == 0),
                        logic'($urandom_range(0, 6) == 0), t);
      end
      rst = 1'b1;
      apply_stimulus(0, 0, 0, 0);
      @(negedge clk);
      cmp_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
